// File: rtl/mem_io_pkg.sv
// Shared definitions for the memory/I-O responder: FSM encoding, data width
// and I/O word offsets relative to the I/O base address.
package mem_io_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] ARG_OFS  = 16'd0;
  localparam logic [DATA_W-1:0] DISP_OFS = 16'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_io_ram.sv
// Single-port synchronous RAM with read-before-write and a registered output
// that only updates on an enabled access, so it holds between accesses.
module mem_io_ram
  import mem_io_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Request/acknowledge responder serving on-chip RAM plus ARGUMENT/DISPLAY
// I/O words, with programmable wait states before a one-cycle ACK.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int              DEPTH_LOG2  = 10,
  parameter int              WAIT_STATES = 2,
  parameter logic [DATA_W-1:0] IO_BASE   = 16'hFF00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] argument,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] display
);

  localparam logic [3:0]        WS        = 4'(WAIT_STATES);
  localparam logic [DATA_W:0]   RAM_WORDS = (DATA_W+1)'(1 << DEPTH_LOG2);
  localparam logic [DATA_W-1:0] ARG_ADDR  = IO_BASE + ARG_OFS;
  localparam logic [DATA_W-1:0] DISP_ADDR = IO_BASE + DISP_OFS;

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              go_resp, commit;
  logic              we_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic              cur_we;
  logic [DATA_W-1:0] cur_addr, cur_wdata;
  logic              is_ram, is_arg, is_disp;
  logic              sel_ram, err_q;
  logic [DATA_W-1:0] io_q, ram_q, display_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    go_resp  = 1'b0;
    case (state)
      ST_IDLE: if (req) begin
        if (WS == 4'd0) begin
          state_nx = ST_RESP;
          go_resp  = 1'b1;
        end else begin
          state_nx = ST_WAIT;
          cnt_nx   = WS - 4'd1;
        end
      end
      ST_WAIT: if (cnt == 4'd0) begin
        state_nx = ST_RESP;
        go_resp  = 1'b1;
      end else begin
        cnt_nx = cnt - 4'd1;
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // A reset on the commit edge aborts the access before anything is written.
  assign commit = go_resp && !reset;

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // With zero wait states the commit edge is the capture edge, so use live inputs.
  assign cur_we    = (state == ST_IDLE) ? we    : we_q;
  assign cur_addr  = (state == ST_IDLE) ? addr  : addr_q;
  assign cur_wdata = (state == ST_IDLE) ? wdata : wdata_q;

  assign is_ram  = {1'b0, cur_addr} < RAM_WORDS;
  assign is_arg  = !is_ram && (cur_addr == ARG_ADDR);
  assign is_disp = !is_ram && !is_arg && (cur_addr == DISP_ADDR);

  mem_io_ram #(.AW(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .en    (commit && is_ram),
    .we    (cur_we),
    .addr  (cur_addr[DEPTH_LOG2-1:0]),
    .wdata (cur_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_ram   <= 1'b0;
      io_q      <= '0;
      err_q     <= 1'b0;
      display_q <= '0;
    end else if (commit) begin
      sel_ram <= is_ram && !cur_we;
      if (cur_we)       io_q <= '0;
      else if (is_arg)  io_q <= argument;
      else if (is_disp) io_q <= display_q;
      else              io_q <= '0;
      err_q <= !(is_ram || is_disp || (is_arg && !cur_we));
      if (is_disp && cur_we) display_q <= cur_wdata;
    end
  end

  assign ack     = (state == ST_RESP);
  assign err     = ack && err_q;
  assign rdata   = sel_ram ? ram_q : io_q;
  assign display = display_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench: one responder with two wait states, one with none.
module tb_mem_io_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req2, we2, req0, we0;
  logic [15:0] addr2, wdata2, addr0, wdata0, argument;
  logic [15:0] rdata2, display2, rdata0, display0;
  logic        ack2, err2, ack0, err0;

  int checks = 0;
  int errors = 0;

  mem_io_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2), .IO_BASE(16'hFF00)) u_dut (
    .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .argument(argument), .rdata(rdata2), .ack(ack2), .err(err2), .display(display2)
  );

  mem_io_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0), .IO_BASE(16'hFF00)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .argument(argument), .rdata(rdata0), .ack(ack0), .err(err0), .display(display0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for ACK, then leave one idle cycle.
  task automatic txn(input bit d0, input bit w, input logic [15:0] a, input logic [15:0] d,
                     output logic [15:0] rd, output logic e, output logic [15:0] dsp,
                     output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    if (d0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else    begin req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d; end
    repeat (20) begin
      @(negedge clk);
      lat++;
      if (d0 ? ack0 : ack2) begin got = 1'b1; break; end
    end
    chk("ack_seen", 32'(got), 32'd1);
    rd  = d0 ? rdata0 : rdata2;
    e   = d0 ? err0 : err2;
    dsp = d0 ? display0 : display2;
    if (d0) req0 = 1'b0; else req2 = 1'b0;
    @(negedge clk);
    chk("ack_width", 32'(d0 ? ack0 : ack2), 32'd0);
  endtask

  logic [15:0] rd, dsp;
  logic        e;
  int          lat;
  logic [15:0] expv [3];
  int          k;

  initial begin
    reset = 1'b1;
    req2 = 0; we2 = 0; addr2 = 0; wdata2 = 0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    argument = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack2), 32'd0);
    chk("rst_err", 32'(err2), 32'd0);
    chk("rst_rdata", 32'(rdata2), 32'h0);
    chk("rst_display", 32'(display2), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // RAM write/read with two wait states
    txn(0, 1, 16'h0005, 16'hBEEF, rd, e, dsp, lat);
    chk("ram_wr_lat", 32'(lat), 32'd3);
    chk("ram_wr_err", 32'(e), 32'd0);
    txn(0, 0, 16'h0005, 16'h0000, rd, e, dsp, lat);
    chk("ram_rd_lat", 32'(lat), 32'd3);
    chk("ram_rd_data", 32'(rd), 32'hBEEF);
    chk("ram_rd_err", 32'(e), 32'd0);

    // ARGUMENT word
    argument = 16'h1234;
    txn(0, 0, 16'hFF00, 16'h0000, rd, e, dsp, lat);
    chk("arg_rd_data", 32'(rd), 32'h1234);
    chk("arg_rd_err", 32'(e), 32'd0);
    txn(0, 1, 16'hFF00, 16'h9999, rd, e, dsp, lat);
    chk("arg_wr_err", 32'(e), 32'd1);
    chk("arg_wr_display", 32'(dsp), 32'h0);
    txn(0, 0, 16'hFF00, 16'h0000, rd, e, dsp, lat);
    chk("arg_rd_again", 32'(rd), 32'h1234);

    // DISPLAY word
    txn(0, 1, 16'hFF01, 16'h00A5, rd, e, dsp, lat);
    chk("disp_wr_ack_cycle", 32'(dsp), 32'h00A5);
    chk("disp_wr_err", 32'(e), 32'd0);
    txn(0, 0, 16'hFF01, 16'h0000, rd, e, dsp, lat);
    chk("disp_rd_data", 32'(rd), 32'h00A5);

    // Unmapped read
    txn(0, 0, 16'h8000, 16'h0000, rd, e, dsp, lat);
    chk("unmap_rd_data", 32'(rd), 32'h0);
    chk("unmap_rd_err", 32'(e), 32'd1);
    chk("unmap_display", 32'(display2), 32'h00A5);
    txn(0, 0, 16'h0005, 16'h0000, rd, e, dsp, lat);
    chk("unmap_ram_kept", 32'(rd), 32'hBEEF);

    // Reset during WAIT aborts a write
    txn(0, 1, 16'h0003, 16'h1111, rd, e, dsp, lat);
    req2 = 1'b1; we2 = 1'b1; addr2 = 16'h0003; wdata2 = 16'h7777;
    @(negedge clk);
    chk("abort_wait_ack", 32'(ack2), 32'd0);
    reset = 1'b1;
    req2  = 1'b0;
    @(negedge clk);
    chk("abort_ack", 32'(ack2), 32'd0);
    chk("abort_display", 32'(display2), 32'h0);
    chk("abort_rdata", 32'(rdata2), 32'h0);
    reset = 1'b0;
    txn(0, 0, 16'h0003, 16'h0000, rd, e, dsp, lat);
    chk("abort_idle_lat", 32'(lat), 32'd3);
    chk("abort_mem_kept", 32'(rd), 32'h1111);

    // Zero wait states, back-to-back reads
    txn(1, 1, 16'h0001, 16'hAAAA, rd, e, dsp, lat);
    chk("ws0_wr_lat", 32'(lat), 32'd1);
    txn(1, 1, 16'h0002, 16'h5555, rd, e, dsp, lat);
    expv[0] = 16'hAAAA; expv[1] = 16'h5555; expv[2] = 16'hAAAA;
    k = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("b2b_ack", 32'(ack0), 32'(i % 2));
      if (ack0 && k < 3) begin
        chk("b2b_rdata", 32'(rdata0), 32'(expv[k]));
        k++;
        addr0 = (k == 1) ? 16'h0002 : 16'h0001;
      end
    end
    req0 = 1'b0;
    chk("b2b_count", 32'(k), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
